uart_rx_frame_ctrl: RTL and testbench

//  Drains the UART RX byte FIFO and parses framed image packets:

---
 rtl/uart_rx_frame_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART RX frame parser: FIFO drain, payload stream, checksum status
//
// Parses SYNC, LEN_HI, LEN_LO, LEN payload bytes and an XOR checksum byte from a
// first-word-fall-through RX FIFO. Payload bytes go out on a valid/ready stream.
// Each frame ends with a one-cycle good or error pulse. Frames that stall on an
// empty FIFO are abandoned after TIMEOUT empty cycles.
//
// Ports:
//   clk           system clock
//   rst_i         synchronous reset, active-high
//   fifo_empty_i  RX FIFO empty flag
//   fifo_data_i   FIFO head word, valid whenever !fifo_empty_i
//   fifo_rd_o     pop FIFO head this cycle (combinational)
//   pix_data_o    payload byte to the image pipeline
//   pix_valid_o   pix_data_o valid
//   pix_ready_i   downstream accepts when pix_valid_o & pix_ready_i
//   pix_last_o    marks the final payload byte of a frame
//   frame_ok_o    1-cycle pulse, checksum matched
//   frame_err_o   1-cycle pulse, checksum mismatch or timeout
//   busy_o        parser is inside a frame
//   frame_cnt_o   count of good frames, wraps 255 -> 0

module uart_rx_frame_ctrl #(
  parameter int                DATA_W    = 8,
  parameter int                LEN_W     = 16,
  parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5,
  parameter int                TIMEOUT   = 50000
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_rd_o,
  output logic [DATA_W-1:0] pix_data_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic              pix_last_o,
  output logic              frame_ok_o,
  output logic              frame_err_o,
  output logic              busy_o,
  output logic [7:0]        frame_cnt_o
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN_HI  = 3'd1;
  localparam logic [2:0] ST_LEN_LO  = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CHK     = 3'd4;

  logic [2:0]        state_q,     state_d;
  logic [DATA_W-1:0] len_hi_q,    len_hi_d;
  logic [LEN_W-1:0]  remain_q,    remain_d;
  logic [DATA_W-1:0] csum_q,      csum_d;
  logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;
  logic [DATA_W-1:0] pix_data_q,  pix_data_d;
  logic              pix_valid_q, pix_valid_d;
  logic              pix_last_q,  pix_last_d;
  logic              frame_ok_q,  frame_ok_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic              fifo_rd;
  logic              pix_free;
  logic              timeout_hit;
  logic [LEN_W-1:0]  len_full;

  // The output register can take a new byte when it is empty or being drained now.
  assign pix_free = !pix_valid_q || pix_ready_i;

  // Length as it will be once LEN_LO is consumed: held high byte plus FIFO head.
  assign len_full = LEN_W'({len_hi_q, fifo_data_i});

  // Fires on the TIMEOUT-th empty cycle since the last pop while inside a frame.
  assign timeout_hit = (state_q != ST_IDLE) && fifo_empty_i &&
                       (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    fifo_rd = 1'b0;
    case (state_q)
      ST_PAYLOAD: fifo_rd = !fifo_empty_i && pix_free;
      default:    fifo_rd = !fifo_empty_i;
    endcase
    // A byte popped during reset would be lost, so hold off until reset is gone.
    if (rst_i) begin
      fifo_rd = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    remain_d    = remain_q;
    csum_d      = csum_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = pix_valid_q;
    pix_last_d  = pix_last_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;

    // Accepted pixel leaves the register; a pop below may refill it this cycle.
    if (pix_valid_q && pix_ready_i) begin
      pix_valid_d = 1'b0;
      pix_last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (fifo_rd && (fifo_data_i == SYNC_BYTE)) begin
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (fifo_rd) begin
          len_hi_d = fifo_data_i;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (fifo_rd) begin
          csum_d   = '0;
          remain_d = len_full;
          state_d  = (len_full == '0) ? ST_CHK : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (fifo_rd) begin
          pix_data_d  = fifo_data_i;
          pix_valid_d = 1'b1;
          pix_last_d  = (remain_q == LEN_W'(1));
          csum_d      = csum_q ^ fifo_data_i;
          remain_d    = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (fifo_rd) begin
          if (fifo_data_i == csum_q) begin
            frame_ok_d  = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort leaves any held pixel untouched so the stream contract survives.
    if (timeout_hit) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end
  end

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == ST_IDLE || fifo_rd || timeout_hit) begin
      to_cnt_d = '0;
    end else if (fifo_empty_i) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      len_hi_q    <= '0;
      remain_q    <= '0;
      csum_q      <= '0;
      to_cnt_q    <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      remain_q    <= remain_d;
      csum_q      <= csum_d;
      to_cnt_q    <= to_cnt_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign fifo_rd_o   = fifo_rd;
  assign pix_data_o  = pix_data_q;
  assign pix_valid_o = pix_valid_q;
  assign pix_last_o  = pix_last_q;
  assign frame_ok_o  = frame_ok_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - self-checking bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;

  localparam int TIMEOUT = 8;

  logic       clk;
  logic       rst_i;
  logic       fifo_empty_i;
  logic [7:0] fifo_data_i;
  logic       fifo_rd_o;
  logic [7:0] pix_data_o;
  logic       pix_valid_o;
  logic       pix_ready_i;
  logic       pix_last_o;
  logic       frame_ok_o;
  logic       frame_err_o;
  logic       busy_o;
  logic [7:0] frame_cnt_o;

  uart_rx_frame_ctrl #(
    .DATA_W(8), .LEN_W(16), .SYNC_BYTE(8'hA5), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_i(rst_i),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i), .fifo_rd_o(fifo_rd_o),
    .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
    .pix_last_o(pix_last_o), .frame_ok_o(frame_ok_o), .frame_err_o(frame_err_o),
    .busy_o(busy_o), .frame_cnt_o(frame_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] bq[$];        // bytes sitting in the modelled RX FIFO
  logic [8:0] exp_pix[$];   // {last, data} expected on the stream, in order
  int         exp_st[$];    // 1 = good frame, 2 = bad frame
  int         pop_cyc[$];
  int         hs_cyc[$];
  int         ok_cyc = -1;
  int         err_cyc = -1;
  bit         gaps_on = 0;
  bit         ready_rand = 0;
  logic       ready_val = 1'b1;
  int         empties_since_pop = 0;
  logic [7:0] mcnt = 8'd0;
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic       prev_l = 1'b0;
  logic [7:0] prev_d = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: condition not met at cycle %0d", name, cyc);
  endtask

  task automatic pb(input logic [7:0] b);
    bq.push_back(b);
  endtask

  task automatic pp(input logic last, input logic [7:0] d);
    exp_pix.push_back({last, d});
  endtask

  // One clock: drive inputs on the falling edge, then check what the DUT shows.
  task automatic step();
    logic [8:0] e;
    int         s;
    @(negedge clk);
    if (bq.size() == 0) fifo_empty_i = 1'b1;
    else if (gaps_on && empties_since_pop < TIMEOUT - 2 && $urandom_range(0, 3) == 0)
      fifo_empty_i = 1'b1;
    else fifo_empty_i = 1'b0;
    fifo_data_i = (bq.size() != 0) ? bq[0] : 8'($urandom);
    pix_ready_i = ready_rand ? ($urandom_range(0, 9) < 7) : ready_val;
    #1;
    cyc++;
    chk("rd_while_empty", {31'd0, fifo_rd_o & fifo_empty_i}, 32'd0);
    if (rst_i) begin
      chk("rd_in_reset", {31'd0, fifo_rd_o}, 32'd0);
      bq.delete();
      exp_pix.delete();
      exp_st.delete();
      mcnt = 8'd0;
      prev_v = 1'b0;
      empties_since_pop = 0;
      return;
    end
    if (fifo_rd_o && !fifo_empty_i) begin
      void'(bq.pop_front());
      pop_cyc.push_back(cyc);
      empties_since_pop = 0;
    end else if (fifo_empty_i) begin
      empties_since_pop++;
    end
    if (prev_v && !prev_r) begin
      chk("hold_valid", {31'd0, pix_valid_o}, 32'd1);
      chk("hold_data", {24'd0, pix_data_o}, {24'd0, prev_d});
      chk("hold_last", {31'd0, pix_last_o}, {31'd0, prev_l});
    end
    if (pix_valid_o && pix_ready_i) begin
      hs_cyc.push_back(cyc);
      if (exp_pix.size() == 0) fail_now("pix_unexpected");
      else begin
        e = exp_pix.pop_front();
        chk("pix", {23'd0, pix_last_o, pix_data_o}, {23'd0, e});
      end
    end
    if (frame_ok_o || frame_err_o) begin
      if (frame_ok_o) ok_cyc = cyc;
      if (frame_err_o) err_cyc = cyc;
      if (exp_st.size() == 0) fail_now("status_unexpected");
      else begin
        s = exp_st.pop_front();
        chk("status", {30'd0, frame_ok_o, frame_err_o}, (s == 1) ? 32'd2 : 32'd1);
        if (s == 1) mcnt = mcnt + 8'd1;
      end
    end
    chk("frame_cnt", {24'd0, frame_cnt_o}, {24'd0, mcnt});
    prev_v = pix_valid_o;
    prev_r = pix_ready_i;
    prev_l = pix_last_o;
    prev_d = pix_data_o;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((bq.size() != 0 || exp_pix.size() != 0 || exp_st.size() != 0) && n < bound) begin
      step();
      n++;
    end
    if (bq.size() != 0 || exp_pix.size() != 0 || exp_st.size() != 0) fail_now("drain_bound");
  endtask

  task automatic wait_bq(input int limit, input int bound);
    int n;
    n = 0;
    while (bq.size() > limit && n < bound) begin
      step();
      n++;
    end
    if (bq.size() > limit) fail_now("fifo_drain_bound");
  endtask

  // Builds a frame from its payload, pushes all or the first `cut` bytes, and
  // records what the stream and status must show for it.
  task automatic push_frame(input int len, input bit corrupt, input int cut);
    logic [7:0]  fr[$];
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [15:0] lv;
    int          n;
    cs = 8'd0;
    lv = len[15:0];
    fr.push_back(8'hA5);
    fr.push_back(lv[15:8]);
    fr.push_back(lv[7:0]);
    for (int i = 0; i < len; i++) begin
      b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
      cs = cs ^ b;
      fr.push_back(b);
    end
    fr.push_back(corrupt ? (cs ^ 8'($urandom_range(1, 255))) : cs);
    n = (cut > 0) ? cut : fr.size();
    for (int i = 0; i < n; i++) bq.push_back(fr[i]);
    for (int i = 0; i < len; i++)
      if (i + 3 < n) exp_pix.push_back({(i == len - 1), fr[i + 3]});
    exp_st.push_back((cut > 0 || corrupt) ? 2 : 1);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, pix_valid_o}, 32'd0);
    chk({tag, "_data"}, {24'd0, pix_data_o}, 32'd0);
    chk({tag, "_last"}, {31'd0, pix_last_o}, 32'd0);
    chk({tag, "_ok"}, {31'd0, frame_ok_o}, 32'd0);
    chk({tag, "_err"}, {31'd0, frame_err_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, frame_cnt_o}, 32'd0);
  endtask

  int n;
  int kind;
  int flen;
  int cut;
  logic [7:0] g;

  initial begin
    rst_i = 1'b1;
    fifo_empty_i = 1'b1;
    fifo_data_i = 8'd0;
    pix_ready_i = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    step();
    check_idle_zero("reset");

    // 1: good 3-byte frame at full rate
    pop_cyc.delete(); hs_cyc.delete();
    pb(8'hA5); pb(8'h00); pb(8'h03); pb(8'h11); pb(8'h22); pb(8'h33); pb(8'h00);
    pp(0, 8'h11); pp(0, 8'h22); pp(1, 8'h33); exp_st.push_back(1);
    drain(100);
    chk("t1_pops", pop_cyc.size(), 7);
    chk("t1_hs", hs_cyc.size(), 3);
    if (pop_cyc.size() == 7 && hs_cyc.size() == 3) begin
      chk("t1_pop_to_valid", hs_cyc[0], pop_cyc[3] + 1);
      chk("t1_rate_a", hs_cyc[1], hs_cyc[0] + 1);
      chk("t1_rate_b", hs_cyc[2], hs_cyc[1] + 1);
      chk("t1_status_lat", ok_cyc, pop_cyc[6] + 1);
    end
    chk("t1_cnt", {24'd0, frame_cnt_o}, 32'd1);

    // 2: same frame, wrong checksum
    pb(8'hA5); pb(8'h00); pb(8'h03); pb(8'h11); pb(8'h22); pb(8'h33); pb(8'h01);
    pp(0, 8'h11); pp(0, 8'h22); pp(1, 8'h33); exp_st.push_back(2);
    drain(100);
    chk("t2_cnt", {24'd0, frame_cnt_o}, 32'd1);

    // 3: garbage before sync
    pop_cyc.delete();
    pb(8'h00); pb(8'hFF); pb(8'h5A); pb(8'hA5); pb(8'h00); pb(8'h01); pb(8'h7E); pb(8'h7E);
    pp(1, 8'h7E); exp_st.push_back(1);
    drain(100);
    chk("t3_pops", pop_cyc.size(), 8);
    chk("t3_cnt", {24'd0, frame_cnt_o}, 32'd2);

    // 4: downstream stall longer than TIMEOUT with a non-empty FIFO
    pb(8'hA5); pb(8'h00); pb(8'h02); pb(8'h44); pb(8'h55); pb(8'h11);
    pp(0, 8'h44); pp(1, 8'h55); exp_st.push_back(1);
    ready_val = 1'b0;
    step();
    n = 0;
    while (!pix_valid_o && n < 20) begin step(); n++; end
    chk("t4_valid_seen", {31'd0, pix_valid_o}, 32'd1);
    repeat (10) begin
      step();
      chk("t4_no_pop", {31'd0, fifo_rd_o}, 32'd0);
      chk("t4_data", {24'd0, pix_data_o}, 32'h44);
      chk("t4_last", {31'd0, pix_last_o}, 32'd0);
      chk("t4_no_err", {31'd0, frame_err_o}, 32'd0);
    end
    ready_val = 1'b1;
    drain(100);
    chk("t4_cnt", {24'd0, frame_cnt_o}, 32'd3);

    // 5: frame stalls on an empty FIFO after the first payload byte
    pop_cyc.delete(); err_cyc = -1;
    pb(8'hA5); pb(8'h00); pb(8'h05); pb(8'h11);
    pp(0, 8'h11); exp_st.push_back(2);
    drain(100);
    chk("t5_pops", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) chk("t5_timeout_lat", err_cyc, pop_cyc[3] + TIMEOUT + 1);
    step();
    chk("t5_busy", {31'd0, busy_o}, 32'd0);
    chk("t5_cnt", {24'd0, frame_cnt_o}, 32'd3);

    // 6: reset mid-payload, then a clean frame
    hs_cyc.delete();
    pb(8'hA5); pb(8'h00); pb(8'h05); pb(8'h01); pb(8'h02); pb(8'h03); pb(8'h04); pb(8'h05); pb(8'h01);
    pp(0, 8'h01); pp(0, 8'h02); pp(0, 8'h03); pp(0, 8'h04); pp(1, 8'h05); exp_st.push_back(1);
    n = 0;
    while (hs_cyc.size() < 2 && n < 50) begin step(); n++; end
    chk("t6_midframe", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    check_idle_zero("t6_after_rst");
    pb(8'hA5); pb(8'h00); pb(8'h01); pb(8'h7E); pb(8'h7E);
    pp(1, 8'h7E); exp_st.push_back(1);
    drain(100);
    chk("t6_cnt", {24'd0, frame_cnt_o}, 32'd1);

    // Random traffic: FIFO gaps, random ready, garbage, corrupt and truncated frames
    gaps_on = 1;
    ready_rand = 1;
    for (int f = 0; f < 420; f++) begin
      kind = $urandom_range(0, 9);
      flen = ($urandom_range(0, 19) == 0) ? 256 + $urandom_range(0, 3) : $urandom_range(0, 6);
      if (kind == 1) begin
        repeat ($urandom_range(1, 3)) begin
          g = 8'($urandom);
          if (g == 8'hA5) g = 8'h3C;
          pb(g);
        end
      end
      if (kind == 0) begin
        cut = $urandom_range(1, flen + 3);
        push_frame(flen, 1'b0, cut);
        wait_bq(0, 5000);
        repeat (TIMEOUT + 3) step();
      end else begin
        push_frame(flen, ($urandom_range(0, 4) == 0), 0);
        wait_bq(3, 5000);
      end
    end
    drain(5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
